udp_payload_extractor: RTL and testbench

- Consumes the received-frame byte stream from the MAC receive wrapper: one byte per valid beat in data[7:0], end_of_frame on the final byte (FCS included, preamble/SFD already stripped).
- Parses the Ethernet II, IPv4 and UDP headers, filters out non-UDP or malformed frames, and emits only the UDP payload as a byte stream with start/last markers for the order-book message decoder.
- No backpressure exists upstream; the block accepts one byte per cycle whenever valid is high.

---
 rtl/udp_payload_extractor.sv | 224 ++++++++++++++++++++++
 tb/tb_udp_payload_extractor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_payload_extractor.sv
// udp_payload_extractor
//   Parses Ethernet II / IPv4 / UDP headers from the MAC receive byte stream
//   and forwards only the UDP payload, with start/last markers, to the
//   order-book message decoder. Non-UDP, fragmented or malformed frames are
//   swallowed and counted as dropped.
//
//   Optional feature macro: UDP_PORT_FILTER_EN
//     defined   -> only datagrams whose destination port equals DST_PORT pass
//     undefined -> every UDP datagram passes, DST_PORT is unused
//
// Ports
//   clk             sole clock
//   reset           synchronous, active-high
//   data_in         upstream data, only [7:0] carries the byte
//   data_valid_in   byte valid (no backpressure, one byte per cycle max)
//   end_of_frame_in last byte of frame (FCS included), qualified by valid
//   payload_data    payload byte, 1 cycle after the input byte
//   payload_valid   payload byte valid
//   payload_start   first payload byte of a datagram
//   payload_last    final payload byte (normal or truncated)
//   udp_dst_port    destination port, stable start..last
//   payload_len     UDP length minus 8, stable start..last
//   trunc_err       pulse when a frame ends before the UDP length is met
//   frames_ok       saturating count of fully delivered datagrams
//   frames_dropped  saturating count of rejected or truncated frames
module udp_payload_extractor #(
    parameter logic [15:0] DST_PORT = 16'd12345,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      data_in,
    input  logic             data_valid_in,
    input  logic             end_of_frame_in,
    output logic [7:0]       payload_data,
    output logic             payload_valid,
    output logic             payload_start,
    output logic             payload_last,
    output logic [15:0]      udp_dst_port,
    output logic [15:0]      payload_len,
    output logic             trunc_err,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_dropped
);

    typedef enum logic [2:0] {S_ETH, S_IP, S_UDP, S_PAY, S_DISCARD} state_t;

    state_t      state_reg;
    logic [10:0] byte_cnt_reg;
    logic [7:0]  eth_hi_reg;      // first EtherType byte
    logic [3:0]  ihl_reg;
    logic        reject_reg;      // IP header failed a check, decided at its end
    logic        drop_on_eof_reg; // S_DISCARD counts the frame as dropped at EOF
    logic [15:0] dst_port_reg;
    logic [15:0] udp_len_reg;
    logic [15:0] remaining_reg;
    logic        first_reg;

    logic [7:0]  byte_in;
    logic [10:0] hdr_end;         // byte index of the first UDP header byte
    logic [10:0] udp_off;
    logic        port_ok;
    logic        udp_done_ok;     // zero-payload datagram completes on this byte
    logic        unused_bits;

    assign byte_in     = data_in[7:0];
    assign hdr_end     = 11'd14 + {5'd0, ihl_reg, 2'b00};
    assign udp_off     = byte_cnt_reg - hdr_end;
    assign unused_bits = ^{data_in[31:8], DST_PORT};

`ifdef UDP_PORT_FILTER_EN
    assign port_ok = (dst_port_reg == DST_PORT);
`else
    assign port_ok = 1'b1;
`endif

    assign udp_done_ok = (udp_off == 11'd7) && port_ok && (udp_len_reg == 16'd8);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_ETH;
            byte_cnt_reg    <= '0;
            eth_hi_reg      <= '0;
            ihl_reg         <= '0;
            reject_reg      <= 1'b0;
            drop_on_eof_reg <= 1'b0;
            dst_port_reg    <= '0;
            udp_len_reg     <= '0;
            remaining_reg   <= '0;
            first_reg       <= 1'b0;
            payload_data    <= '0;
            payload_valid   <= 1'b0;
            payload_start   <= 1'b0;
            payload_last    <= 1'b0;
            udp_dst_port    <= '0;
            payload_len     <= '0;
            trunc_err       <= 1'b0;
            frames_ok       <= '0;
            frames_dropped  <= '0;
        end else begin
            payload_valid <= 1'b0;
            payload_start <= 1'b0;
            payload_last  <= 1'b0;
            trunc_err     <= 1'b0;

            if (data_valid_in) begin
                if (byte_cnt_reg != '1)
                    byte_cnt_reg <= byte_cnt_reg + 11'd1;

                case (state_reg)
                    S_ETH: begin
                        if (byte_cnt_reg == 11'd12)
                            eth_hi_reg <= byte_in;
                        if (byte_cnt_reg == 11'd13) begin
                            if ({eth_hi_reg, byte_in} == 16'h0800) begin
                                state_reg <= S_IP;
                            end else begin
                                state_reg       <= S_DISCARD;
                                drop_on_eof_reg <= 1'b1;
                            end
                        end
                        if (end_of_frame_in)
                            frames_dropped <= sat_inc(frames_dropped);
                    end

                    S_IP: begin
                        if (byte_cnt_reg == 11'd14) begin
                            reject_reg <= 1'b0;
                            ihl_reg    <= byte_in[3:0];
                            // Without a usable IHL the header end is unknown,
                            // so the frame is abandoned right away.
                            if (byte_in[7:4] != 4'd4 || byte_in[3:0] < 4'd5) begin
                                state_reg       <= S_DISCARD;
                                drop_on_eof_reg <= 1'b1;
                            end
                        end else begin
                            // Byte 20: [5]=MF, [4:0]=offset high bits
                            if (byte_cnt_reg == 11'd20 && (byte_in[5] || byte_in[4:0] != 5'd0))
                                reject_reg <= 1'b1;
                            if (byte_cnt_reg == 11'd21 && byte_in != 8'd0)
                                reject_reg <= 1'b1;
                            if (byte_cnt_reg == 11'd23 && byte_in != 8'd17)
                                reject_reg <= 1'b1;
                            if (byte_cnt_reg == hdr_end - 11'd1) begin
                                if (reject_reg) begin
                                    state_reg       <= S_DISCARD;
                                    drop_on_eof_reg <= 1'b1;
                                end else begin
                                    state_reg <= S_UDP;
                                end
                            end
                        end
                        if (end_of_frame_in)
                            frames_dropped <= sat_inc(frames_dropped);
                    end

                    S_UDP: begin
                        case (udp_off)
                            11'd2: dst_port_reg[15:8] <= byte_in;
                            11'd3: dst_port_reg[7:0]  <= byte_in;
                            11'd4: udp_len_reg[15:8]  <= byte_in;
                            11'd5: udp_len_reg[7:0]   <= byte_in;
                            default: ;
                        endcase
                        if (udp_off == 11'd7) begin
                            if (!port_ok || udp_len_reg < 16'd8) begin
                                state_reg       <= S_DISCARD;
                                drop_on_eof_reg <= 1'b1;
                            end else if (udp_len_reg == 16'd8) begin
                                frames_ok       <= sat_inc(frames_ok);
                                state_reg       <= S_DISCARD;
                                drop_on_eof_reg <= 1'b0;
                            end else begin
                                remaining_reg <= udp_len_reg - 16'd8;
                                payload_len   <= udp_len_reg - 16'd8;
                                udp_dst_port  <= dst_port_reg;
                                first_reg     <= 1'b1;
                                state_reg     <= S_PAY;
                            end
                        end
                        if (end_of_frame_in && !udp_done_ok)
                            frames_dropped <= sat_inc(frames_dropped);
                    end

                    S_PAY: begin
                        payload_data  <= byte_in;
                        payload_valid <= 1'b1;
                        payload_start <= first_reg;
                        payload_last  <= (remaining_reg == 16'd1) || end_of_frame_in;
                        first_reg     <= 1'b0;
                        remaining_reg <= remaining_reg - 16'd1;
                        if (remaining_reg == 16'd1) begin
                            frames_ok       <= sat_inc(frames_ok);
                            state_reg       <= S_DISCARD;
                            drop_on_eof_reg <= 1'b0;
                        end else if (end_of_frame_in) begin
                            trunc_err      <= 1'b1;
                            frames_dropped <= sat_inc(frames_dropped);
                        end
                    end

                    S_DISCARD: begin
                        if (end_of_frame_in && drop_on_eof_reg)
                            frames_dropped <= sat_inc(frames_dropped);
                    end

                    default: state_reg <= S_ETH;
                endcase

                // Frame boundary overrides whatever the state decided above.
                if (end_of_frame_in) begin
                    state_reg       <= S_ETH;
                    byte_cnt_reg    <= '0;
                    drop_on_eof_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_payload_extractor.sv
module tb_udp_payload_extractor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        data_valid_in;
    logic        end_of_frame_in;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        payload_start;
    logic        payload_last;
    logic [15:0] udp_dst_port;
    logic [15:0] payload_len;
    logic        trunc_err;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    udp_payload_extractor #(.DST_PORT(16'd12345), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .end_of_frame_in(end_of_frame_in),
        .payload_data   (payload_data),
        .payload_valid  (payload_valid),
        .payload_start  (payload_start),
        .payload_last   (payload_last),
        .udp_dst_port   (udp_dst_port),
        .payload_len    (payload_len),
        .trunc_err      (trunc_err),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  d;
        logic        s;
        logic        l;
        logic        t;
        logic [15:0] port;
        logic [15:0] len;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          frame_no = 0;
    int          exp_ok = 0;
    int          exp_drop = 0;
    int          beat_total = 0;
    int          b0;
    logic [7:0]  frm[$];
    beat_t       exp_q[$];
    logic [7:0]  log_data[256];
    int          log_rel[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Compare process: every cycle out of reset, payload outputs must match
    // the next beat predicted by the model, and flags must be quiet otherwise.
    always @(negedge clk) begin
        beat_t e;
        if (!reset) begin
            if (payload_valid) begin
                log_data[beat_total % 256] = payload_data;
                log_rel[beat_total % 256]  = cyc - start_cyc;
                beat_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat act=%h req=none", payload_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({payload_data, payload_start, payload_last, trunc_err, udp_dst_port, payload_len} !== e) begin
                        errors++;
                        $display("FAIL beat act=%h/%b%b%b/%0d/%0d req=%h/%b%b%b/%0d/%0d",
                                 payload_data, payload_start, payload_last, trunc_err, udp_dst_port, payload_len,
                                 e.d, e.s, e.l, e.t, e.port, e.len);
                    end
                end
            end else begin
                checks++;
                if ({payload_start, payload_last, trunc_err} !== 3'b000) begin
                    errors++;
                    $display("FAIL idle_flags act=%b req=000", {payload_start, payload_last, trunc_err});
                end
            end
        end
    end

    // Frame construction: Ethernet + IPv4 (IHL from vihl) + UDP header.
    task automatic build(input logic [15:0] et, input logic [7:0] vihl, input logic [7:0] b20,
                         input logic [7:0] proto, input logic [15:0] dport, input logic [15:0] ulen);
        int nopt;
        frm.delete();
        for (int i = 0; i < 12; i++) frm.push_back(8'(8'h10 + i));
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        frm.push_back(vihl);  frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h30);
        frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(b20);   frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(proto); frm.push_back(8'hAB); frm.push_back(8'hCD);
        for (int i = 0; i < 8; i++) frm.push_back(8'(8'hC0 + i));
        nopt = (int'(vihl[3:0]) - 5) * 4;
        for (int i = 0; i < nopt; i++) frm.push_back(8'hEE);
        frm.push_back(8'h04); frm.push_back(8'hD2);
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
    endtask

    task automatic add(input logic [7:0] b);
        frm.push_back(b);
    endtask

    task automatic pad(input int k);
        for (int i = 0; i < k; i++) frm.push_back(8'h55);
    endtask

    // Behavioural model: decides the fate of the whole frame from its bytes.
    task automatic model_frame();
        int          n, hl, plen, avail, k;
        logic [7:0]  b14, b20, b21, b23;
        logic [15:0] et, dport, ulen;
        logic        bad;
        beat_t       e;
        n = frm.size();
        if (n < 15) begin exp_drop++; return; end
        et  = {frm[12], frm[13]};
        b14 = frm[14];
        if (et != 16'h0800 || b14[7:4] != 4'd4 || b14[3:0] < 4'd5) begin exp_drop++; return; end
        hl = 14 + 4 * int'(b14[3:0]);
        if (n < hl + 8) begin exp_drop++; return; end
        b20 = frm[20]; b21 = frm[21]; b23 = frm[23];
        bad   = b20[5] || (b20[4:0] != 5'd0) || (b21 != 8'd0) || (b23 != 8'd17);
        dport = {frm[hl+2], frm[hl+3]};
        ulen  = {frm[hl+4], frm[hl+5]};
`ifdef UDP_PORT_FILTER_EN
        if (dport != 16'd12345) bad = 1'b1;
`endif
        if (bad || ulen < 16'd8) begin exp_drop++; return; end
        if (ulen == 16'd8) begin exp_ok++; return; end
        plen  = int'(ulen) - 8;
        avail = n - (hl + 8);
        k     = (avail < plen) ? avail : plen;
        for (int i = 0; i < k; i++) begin
            e.d    = frm[hl + 8 + i];
            e.s    = (i == 0);
            e.l    = (i == k - 1);
            e.t    = (i == k - 1) && (avail < plen);
            e.port = dport;
            e.len  = 16'(plen);
            exp_q.push_back(e);
        end
        if (avail >= plen) exp_ok++; else exp_drop++;
    endtask

    // Drive the frame; gap inserts one idle cycle after every byte,
    // abort_at >= 0 stops before that byte index (no end of frame).
    task automatic send_frame(input int gap, input int abort_at);
        frame_no++;
        $display("frame %0d: %0d bytes gap=%0d abort_at=%0d", frame_no, frm.size(), gap, abort_at);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == abort_at) break;
            @(posedge clk); #1;
            if (i == 0) start_cyc = cyc;
            data_in         = {24'h5A5A5A, frm[i]};
            data_valid_in   = 1'b1;
            end_of_frame_in = (i == frm.size() - 1);
            if (gap != 0) begin
                @(posedge clk); #1;
                data_valid_in   = 1'b0;
                end_of_frame_in = 1'b0;
                data_in         = 32'hFFFF_FF00;
            end
        end
        @(posedge clk); #1;
        data_valid_in   = 1'b0;
        end_of_frame_in = 1'b0;
    endtask

    task automatic check_counters();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("frames_ok", 76'(frames_ok), 76'(exp_ok));
        check("frames_dropped", 76'(frames_dropped), 76'(exp_drop));
        check("beats_pending", 76'(exp_q.size()), 76'd0);
    endtask

    task automatic run(input int gap);
        b0 = beat_total;
        model_frame();
        send_frame(gap, -1);
        check_counters();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_q.delete();
        exp_ok   = 0;
        exp_drop = 0;
    endtask

    task automatic frame1();
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12345, 16'd12);
        add(8'hDE); add(8'hAD); add(8'hBE); add(8'hEF);
        pad(22);
    endtask

    initial begin
        reset           = 1'b1;
        data_in         = '0;
        data_valid_in   = 1'b0;
        end_of_frame_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check("reset_state", {payload_data, payload_valid, payload_start, payload_last, udp_dst_port,
                              payload_len, trunc_err, frames_ok, frames_dropped}, 76'd0);

        // Valid DE AD BE EF datagram
        frame1();
        check("model_len", 76'(frm.size()), 76'd68);
        run(0);
        check("t1_beats", 76'(beat_total - b0), 76'd4);
        check("t1_bytes", {log_data[b0 % 256], log_data[(b0+1) % 256], log_data[(b0+2) % 256], log_data[(b0+3) % 256]}, 76'hDEADBEEF);
        check("t1_first_cycle", 76'(log_rel[b0 % 256]), 76'd43);
        check("t1_last_cycle", 76'(log_rel[(b0+3) % 256]), 76'd46);
        check("t1_payload_len", 76'(payload_len), 76'd4);
        check("t1_dst_port", 76'(udp_dst_port), 76'd12345);
        check("t1_frames_ok", 76'(frames_ok), 76'd1);

        // IPv6 EtherType, 64 bytes
        build(16'h86DD, 8'h60, 8'h00, 8'd17, 16'd12345, 16'd12);
        pad(22);
        run(0);
        check("t2_beats", 76'(beat_total - b0), 76'd0);
        check("t2_dropped", 76'(frames_dropped), 76'd1);

        // IHL=6 with options, payload 01 02
        build(16'h0800, 8'h46, 8'h00, 8'd17, 16'd12345, 16'd10);
        add(8'h01); add(8'h02); pad(20);
        run(0);
        check("t3_bytes", {log_data[b0 % 256], log_data[(b0+1) % 256]}, 76'h0102);
        check("t3_first_cycle", 76'(log_rel[b0 % 256]), 76'd47);
        check("t3_frames_ok", 76'(frames_ok), 76'd2);

        // UDP length 20, frame ends after 5 payload bytes
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12345, 16'd20);
        for (int i = 0; i < 5; i++) add(8'(8'hA0 + i));
        run(0);
        check("t4_beats", 76'(beat_total - b0), 76'd5);
        check("t4_counts", {frames_ok, frames_dropped}, {16'd2, 16'd2});

        // Same as frame 1 with valid toggling
        frame1();
        run(1);
        check("t5_bytes", {log_data[b0 % 256], log_data[(b0+1) % 256], log_data[(b0+2) % 256], log_data[(b0+3) % 256]}, 76'hDEADBEEF);

        // Reset mid-payload, then a clean frame
        frame1();
        model_frame();
        send_frame(0, 44);
        do_reset();
        @(negedge clk); #1;
        check("reset_mid", {payload_data, payload_valid, payload_start, payload_last, udp_dst_port,
                            payload_len, trunc_err, frames_ok, frames_dropped}, 76'd0);
        frame1();
        run(0);
        check("t6_frames_ok", 76'(frames_ok), 76'd1);

        // Boundary and rejection cases, judged by the model
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12345, 16'd8);  pad(18); run(0);
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12345, 16'd5);  pad(18); run(0);
        build(16'h0800, 8'h45, 8'h00, 8'd6,  16'd12345, 16'd12); add(8'h11); add(8'h22); pad(20); run(0);
        build(16'h0800, 8'h45, 8'h20, 8'd17, 16'd12345, 16'd12); add(8'h11); add(8'h22); pad(20); run(0);
        build(16'h0800, 8'h45, 8'h01, 8'd17, 16'd12345, 16'd12); add(8'h11); add(8'h22); pad(20); run(0);
        build(16'h0800, 8'h45, 8'h40, 8'd17, 16'd12345, 16'd11); add(8'h31); add(8'h32); add(8'h33); pad(20); run(0);
        build(16'h0800, 8'h65, 8'h00, 8'd17, 16'd12345, 16'd12); add(8'h11); pad(20); run(0);
        build(16'h0800, 8'h44, 8'h00, 8'd17, 16'd12345, 16'd12); add(8'h11); pad(20); run(0);
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12345, 16'd10); add(8'h77); add(8'h88); run(0);
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12345, 16'd12); run(0);
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12345, 16'd12);
        while (frm.size() > 10) void'(frm.pop_back());
        run(0);
        build(16'h0800, 8'h45, 8'h00, 8'd17, 16'd12346, 16'd12);
        add(8'h99); add(8'h98); add(8'h97); add(8'h96); pad(22);
        run(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
